period_meter: RTL and testbench



---
 rtl/period_meter_pkg.sv | 12 +
 rtl/period_meter_edge_det.sv | 19 +
 rtl/period_meter.sv | 134 +++++++++++++
 tb/tb_period_meter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

   localparam int DIV_W         = 3;
   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_e;

endpackage

// File: rtl/period_meter_edge_det.sv
// Rising-edge detector: registers q into q_d and flags cycles where q=1 and q_d=0.
module edge_det (
   input  logic clk,
   input  logic reset,
   input  logic q,
   output logic rise
);

   logic q_d;

   // Reset also loads the live input so the first cycle after reset never sees an edge.
   always_ff @(posedge clk) begin
      if (reset) q_d <= q;
      else       q_d <= q;
   end

   assign rise = q & ~q_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of the divided waveform q, with a valid/ready result port.
// Optional period-vs-divisor check is built when PERIOD_METER_CHECK_EN is defined.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             q,
   input  logic [DIV_W-1:0] div,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             overrun,
   output logic             timeout,
   output logic             mismatch
);

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q;
   logic [CNT_W-1:0]   cnt_q, hcnt_q;
   logic [CNT_W-1:0]   period_q, high_q;
   logic               valid_q, overrun_q, timeout_q;

   logic               edge_s;
   logic               div_chg;
   logic               cnt_max;
   logic               start_s, latch_s, count_s, tmo_s;
   logic               load_res;

   edge_det u_edge_det (
      .clk   (clk),
      .reset (reset),
      .q     (q),
      .rise  (edge_s)
   );

   assign div_chg = (div != div_q);
   assign cnt_max = (cnt_q == {CNT_W{1'b1}});

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!div_chg && edge_s)            state_d = MEASURE;
         MEASURE: if (div_chg || (!edge_s && cnt_max)) state_d = IDLE;
         default:                                    state_d = IDLE;
      endcase
   end

   always_comb begin
      start_s = 1'b0;
      latch_s = 1'b0;
      count_s = 1'b0;
      tmo_s   = 1'b0;
      unique case (state_q)
         IDLE:    start_s = edge_s && !div_chg;
         MEASURE: begin
            latch_s = edge_s && !div_chg;
            count_s = !edge_s && !div_chg && !cnt_max;
            tmo_s   = !edge_s && !div_chg && cnt_max;
         end
         default: ;
      endcase
   end

   // A new result is taken only if the slot is free or is being emptied this cycle.
   assign load_res = latch_s && (!valid_q || meas_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= div;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         div_q     <= div;
         timeout_q <= tmo_s;

         if (start_s || latch_s) begin
            cnt_q  <= CNT_W'(1);
            hcnt_q <= CNT_W'(1);
         end else if (count_s) begin
            cnt_q <= cnt_q + 1'b1;
            if (q) hcnt_q <= hcnt_q + 1'b1;
         end

         if (load_res) begin
            period_q <= cnt_q;
            high_q   <= hcnt_q;
            valid_q  <= 1'b1;
         end else if (valid_q && meas_ready) begin
            valid_q  <= 1'b0;
         end

         if (latch_s && valid_q && !meas_ready) overrun_q <= 1'b1;
      end
   end

`ifdef PERIOD_METER_CHECK_EN
   logic             mismatch_q;
   logic [CNT_W:0]   twice_div;

   assign twice_div = (CNT_W+1)'(div_q) << 1;

   always_ff @(posedge clk) begin
      if (reset)         mismatch_q <= 1'b0;
      else if (load_res) mismatch_q <= ({1'b0, cnt_q} != twice_div);
   end

   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif

   assign period     = period_q;
   assign high       = high_q;
   assign meas_valid = valid_q;
   assign overrun    = overrun_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter; expected values are hand-computed per scenario.
module tb_period_meter;
   import period_meter_pkg::*;

   localparam int CW = 8;
`ifdef PERIOD_METER_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          q;
   logic [2:0]    div;
   logic [CW-1:0] period, high;
   logic          meas_valid, meas_ready, overrun, timeout, mismatch;

   int total = 0;
   int bad   = 0;
   int ph    = 0;
   int vcnt, tcnt, tpos;

   period_meter #(.CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .q          (q),
      .div        (div),
      .period     (period),
      .high       (high),
      .meas_valid (meas_valid),
      .meas_ready (meas_ready),
      .overrun    (overrun),
      .timeout    (timeout),
      .mismatch   (mismatch)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q     = 1'b0;
      ph    = 0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Drives n cycles of a hi/lo waveform continuing from phase ph; tallies valid and timeout.
   task automatic drive(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         q  = (ph < hi);
         ph = (ph + 1) % (hi + lo);
         tick();
         if (meas_valid) vcnt++;
         if (timeout)    tcnt++;
      end
   endtask

   initial begin
      reset      = 1'b1;
      q          = 1'b0;
      div        = 3'd2;
      meas_ready = 1'b1;

      // Reset state
      do_reset();
      check("rst_valid",    32'(meas_valid), 0);
      check("rst_period",   32'(period),     0);
      check("rst_high",     32'(high),       0);
      check("rst_overrun",  32'(overrun),    0);
      check("rst_timeout",  32'(timeout),    0);
      check("rst_mismatch", 32'(mismatch),   0);
      check("rst_state",    32'(dut.state_q), 32'(IDLE));

      // div=2, 2/2 waveform, always ready: one result every 4 cycles
      vcnt = 0;
      drive(20, 2, 2);
      check("d2_valid_pulses", 32'(vcnt),     4);
      check("d2_period",       32'(period),   4);
      check("d2_high",         32'(high),     2);
      check("d2_mismatch",     32'(mismatch), 0);

      // div=3, 3/3 waveform, consumer stalled: first result held, later ones dropped
      div        = 3'd3;
      meas_ready = 1'b0;
      do_reset();
      drive(7, 3, 3);
      check("d3_first_valid",   32'(meas_valid), 1);
      check("d3_first_period",  32'(period),     6);
      check("d3_first_high",    32'(high),       3);
      check("d3_first_overrun", 32'(overrun),    0);
      check("d3_first_mm",      32'(mismatch),   0);
      drive(17, 3, 3);
      check("d3_held_valid",   32'(meas_valid), 1);
      check("d3_held_period",  32'(period),     6);
      check("d3_held_high",    32'(high),       3);
      check("d3_held_overrun", 32'(overrun),    1);

      // New result coinciding with a handshake replaces the old one
      drive(4, 2, 2);
      meas_ready = 1'b1;
      drive(1, 2, 2);
      check("hs_valid",    32'(meas_valid), 1);
      check("hs_period",   32'(period),     4);
      check("hs_high",     32'(high),       2);
      check("hs_overrun",  32'(overrun),    1);
      check("hs_mismatch", 32'(mismatch),   32'(CHK));
      meas_ready = 1'b0;

      // Reset with a pending result and overrun set
      reset = 1'b1;
      tick();
      check("rr_valid",    32'(meas_valid), 0);
      check("rr_period",   32'(period),     0);
      check("rr_high",     32'(high),       0);
      check("rr_overrun",  32'(overrun),    0);
      check("rr_timeout",  32'(timeout),    0);
      check("rr_mismatch", 32'(mismatch),   0);
      check("rr_state",    32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;

      // q stuck low, then stuck high, after one starting edge: single timeout only
      div        = 3'd2;
      meas_ready = 1'b1;
      do_reset();
      for (int v = 0; v < 2; v++) begin
         tcnt = 0;
         vcnt = 0;
         tpos = -1;
         q    = 1'b1;
         tick();
         for (int i = 1; i <= 300; i++) begin
            q = v[0];
            tick();
            if (timeout) begin
               tcnt++;
               tpos = i;
            end
            if (meas_valid) vcnt++;
         end
         check($sformatf("stuck%0d_tmo_count", v), 32'(tcnt), 1);
         check($sformatf("stuck%0d_tmo_pos", v),   32'(tpos), 255);
         check($sformatf("stuck%0d_valid", v),     32'(vcnt), 0);
         check($sformatf("stuck%0d_state", v),     32'(dut.state_q), 32'(IDLE));
      end

      // Divisor change mid-period discards the partial measurement
      div        = 3'd2;
      meas_ready = 1'b1;
      do_reset();
      vcnt = 0;
      drive(6, 2, 2);
      check("dc_pre_pulses", 32'(vcnt), 1);
      div  = 3'd5;
      ph   = 5;
      vcnt = 0;
      drive(15, 5, 5);
      check("dc_no_result", 32'(vcnt), 0);
      drive(1, 5, 5);
      check("dc_valid",    32'(meas_valid), 1);
      check("dc_period",   32'(period),     10);
      check("dc_high",     32'(high),       5);
      check("dc_mismatch", 32'(mismatch),   0);

      // div=4 with a 3/3 waveform: period 6 disagrees with 2*div in the check build
      div        = 3'd4;
      meas_ready = 1'b1;
      do_reset();
      drive(7, 3, 3);
      check("d4_valid",    32'(meas_valid), 1);
      check("d4_period",   32'(period),     6);
      check("d4_high",     32'(high),       3);
      check("d4_mismatch", 32'(mismatch),   32'(CHK));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
